// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit timing and parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DEFAULT_CYCLES_PER_BIT = 16;
    localparam int unsigned DATA_BITS              = 8;

    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD  = 1'b1;

    // Parity bit for a data byte; odd mode inverts the even-parity result.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter shared by the UART transmitter and receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_end_c,
    output logic mid_bit_c
);

    localparam int unsigned       CNT_W    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CYCLES_PER_BIT / 2);

    logic [CNT_W-1:0] bit_cnt;

    // Counts 0..CYCLES_PER_BIT-1 while enabled, wrapping at the end of each bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (en) begin
            bit_cnt <= bit_end_c ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    assign bit_end_c = en && (bit_cnt == CNT_LAST);
    assign mid_bit_c = en && (bit_cnt == CNT_MID);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1-entry holding buffer feeding a start/8 data/parity/stop serialiser.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter bit          PARITY_EN      = 1'b1,
    parameter bit          PARITY_ODD     = PARITY_MODE_EVEN
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Clear,
    input  logic [DATA_BITS-1:0] InData,
    input  logic                 InValid,
    output logic                 InReady,
    output logic                 TX,
    output logic                 Busy,
    output logic                 DonePluse
);

    uart_state_e           state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
    logic [2:0]            data_cnt_q, data_cnt_d;
    logic                  hold_full_q, hold_full_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  in_ready_q, in_ready_d;
    logic                  accept_c;
    logic                  load_c;
    logic                  bit_end_c;
    logic                  mid_bit_unused;

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bit_timer (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .en       (state_q != IDLE),
        .clr      (Clear),
        .bit_end_c(bit_end_c),
        .mid_bit_c(mid_bit_unused)
    );

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_data_q <= '0;
            data_cnt_q  <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            data_cnt_q  <= data_cnt_d;
            hold_full_q <= hold_full_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, buffer handshake and registered-output values.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        data_cnt_d  = data_cnt_q;
        hold_full_d = hold_full_q;
        parity_d    = parity_q;
        done_d      = 1'b0;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        load_c      = 1'b0;
        accept_c    = InValid && in_ready_q;

        if (accept_c) begin
            hold_data_d = InData;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                    load_c  = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) state_d = DATA;
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
                    data_cnt_d = data_cnt_q + 3'd1;
                    if (data_cnt_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end_c) state_d = STOP;
            end
            STOP: begin
                if (bit_end_c) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        state_d = START;
                        load_c  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept and load are exclusive: accept needs an empty buffer, load a full one.
        if (load_c) begin
            shift_d     = hold_data_q;
            parity_d    = parity_of(hold_data_q, PARITY_ODD);
            data_cnt_d  = '0;
            hold_full_d = 1'b0;
        end

        if (Clear) begin
            state_d     = IDLE;
            shift_d     = '0;
            hold_data_d = '0;
            data_cnt_d  = '0;
            hold_full_d = 1'b0;
            parity_d    = 1'b0;
            done_d      = 1'b0;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase

        busy_d     = (state_d != IDLE) || hold_full_d;
        in_ready_d = !hold_full_d;
    end

    assign InReady   = in_ready_q;
    assign TX        = tx_q;
    assign Busy      = busy_q;
    assign DonePluse = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: framing, handshake, back-to-back, clear, parity modes.
module tb_uart_tx;

    logic       Clk       = 1'b0;
    logic       Rst_n     = 1'b0;
    logic       Clear     = 1'b0;
    logic [7:0] InData    = 8'h00;
    logic       valid_main = 1'b0;
    logic       valid_aux  = 1'b0;

    logic ready_main, tx_main, busy_main, done_main;
    logic ready_odd,  tx_odd,  busy_odd,  done_odd;
    logic ready_np,   tx_np,   busy_np,   done_np;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0] rx_exp [4] = '{8'h00, 8'h55, 8'hFF, 8'h81};

    uart_tx dut (
        .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .InData(InData), .InValid(valid_main),
        .InReady(ready_main), .TX(tx_main), .Busy(busy_main), .DonePluse(done_main)
    );

    uart_tx #(.PARITY_ODD(1'b1)) dut_odd (
        .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .InData(InData), .InValid(valid_aux),
        .InReady(ready_odd), .TX(tx_odd), .Busy(busy_odd), .DonePluse(done_odd)
    );

    uart_tx #(.PARITY_EN(1'b0)) dut_np (
        .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .InData(InData), .InValid(valid_aux),
        .InReady(ready_np), .TX(tx_np), .Busy(busy_np), .DonePluse(done_np)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (done_main === 1'b1) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a byte from a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        InData     = d;
        valid_main = 1'b1;
        while (ready_main !== 1'b1 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("send_ready_wait", 32'(n < 400), 1);
        @(negedge Clk);
        valid_main = 1'b0;
    endtask

    // frame = {stop, parity, data[7:0], start}; cycle j of the frame shows frame[(j-1)/16].
    task automatic check_frame(input string tag, input logic [10:0] frame, input int nbits,
                               input bit skip_first);
        for (int j = skip_first ? 2 : 1; j <= nbits * 16; j++) begin
            @(negedge Clk);
            chk({tag, "_tx"}, 32'(tx_main), 32'(frame[4'((j - 1) / 16)]));
            chk({tag, "_done_low"}, 32'(done_main), 0);
        end
    endtask

    // Mid-bit sampling receiver: fr[7:0] data, fr[8] parity, fr[9] stop.
    task automatic rx_byte(output logic [9:0] fr, output bit found);
        int n = 0;
        fr = '0;
        while (tx_main !== 1'b0 && n < 600) begin
            @(negedge Clk);
            n++;
        end
        found = (n < 600);
        repeat (23) @(negedge Clk);
        for (int i = 0; i < 10; i++) begin
            fr[i] = tx_main;
            if (i < 9) repeat (16) @(negedge Clk);
        end
    endtask

    initial begin
        int         base;
        logic [9:0] fr;
        bit         found;
        logic       e_odd, e_np;
        logic [10:0] exp_odd = 11'b1_0_00000001_0;
        logic [9:0]  exp_np  = 10'b1_00000001_0;

        // Reset values while held in reset, then a long idle stretch
        repeat (3) @(negedge Clk);
        chk("rst_tx", 32'(tx_main), 1);
        chk("rst_ready", 32'(ready_main), 1);
        chk("rst_busy", 32'(busy_main), 0);
        chk("rst_done", 32'(done_main), 0);
        Rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            chk("idle_tx", 32'(tx_main), 1);
            chk("idle_ready", 32'(ready_main), 1);
            chk("idle_busy", 32'(busy_main), 0);
            chk("idle_done", 32'(done_main), 0);
        end
        chk("idle_done_cnt", 32'(done_cnt), 0);

        // 0xA5 even parity: TX still high right after accept, done 177 cycles later
        send_byte(8'hA5);
        chk("a5_lat_tx", 32'(tx_main), 1);
        chk("a5_lat_ready", 32'(ready_main), 0);
        chk("a5_lat_busy", 32'(busy_main), 1);
        check_frame("a5", 11'b1_0_10100101_0, 11, 1'b0);
        @(negedge Clk);
        chk("a5_done", 32'(done_main), 1);
        chk("a5_end_tx", 32'(tx_main), 1);
        chk("a5_end_busy", 32'(busy_main), 0);
        @(negedge Clk);
        chk("a5_done_once", 32'(done_main), 0);

        // 0x07 has odd weight, so even parity bit is 1
        send_byte(8'h07);
        check_frame("x07", 11'b1_1_00000111_0, 11, 1'b0);
        @(negedge Clk);
        chk("x07_done", 32'(done_main), 1);
        @(negedge Clk);

        // Back-to-back: 0xFF offered while not ready, accepted after the 0x00 load
        send_byte(8'h00);
        InData     = 8'hFF;
        valid_main = 1'b1;
        fork
            check_frame("b2b0", 11'b1_0_00000000_0, 11, 1'b0);
            begin
                @(negedge Clk);
                chk("b2b_ready_after_load", 32'(ready_main), 1);
                @(negedge Clk);
                valid_main = 1'b0;
                chk("b2b_ready_full", 32'(ready_main), 0);
                repeat (100) @(negedge Clk);
                chk("b2b_ready_mid", 32'(ready_main), 0);
            end
        join
        @(negedge Clk);
        chk("b2b0_done", 32'(done_main), 1);
        chk("b2b_no_gap_tx", 32'(tx_main), 0);
        chk("b2b_ready_reload", 32'(ready_main), 1);
        check_frame("b2b1", 11'b1_0_11111111_0, 11, 1'b1);
        @(negedge Clk);
        chk("b2b1_done", 32'(done_main), 1);
        chk("b2b1_end_tx", 32'(tx_main), 1);
        chk("b2b1_end_busy", 32'(busy_main), 0);
        @(negedge Clk);

        // Loopback through a sampling receiver, four bytes streamed
        base = done_cnt;
        fork
            for (int b = 0; b < 4; b++) send_byte(rx_exp[b]);
            for (int b = 0; b < 4; b++) begin
                rx_byte(fr, found);
                chk("rx_found", 32'(found), 1);
                chk("rx_data", 32'(fr[7:0]), 32'(rx_exp[b]));
                chk("rx_parity", 32'(fr[8]), 0);
                chk("rx_stop", 32'(fr[9]), 1);
            end
        join
        repeat (12) @(negedge Clk);
        chk("rx_done_count", 32'(done_cnt - base), 4);
        chk("rx_end_busy", 32'(busy_main), 0);

        // Clear during data bit 3 with the buffer full
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (68) @(negedge Clk);
        chk("clr_pre_tx", 32'(tx_main), 0);
        chk("clr_pre_busy", 32'(busy_main), 1);
        chk("clr_pre_ready", 32'(ready_main), 0);
        base  = done_cnt;
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        chk("clr_tx", 32'(tx_main), 1);
        chk("clr_busy", 32'(busy_main), 0);
        chk("clr_ready", 32'(ready_main), 1);
        chk("clr_done", 32'(done_main), 0);
        repeat (40) @(negedge Clk);
        chk("clr_flushed_tx", 32'(tx_main), 1);
        chk("clr_flushed_busy", 32'(busy_main), 0);
        chk("clr_no_done", 32'(done_cnt - base), 0);
        send_byte(8'h3C);
        check_frame("x3c", 11'b1_0_00111100_0, 11, 1'b0);
        @(negedge Clk);
        chk("x3c_done", 32'(done_main), 1);
        @(negedge Clk);

        // Odd parity of 0x01 is 0; no-parity frame is 160 cycles
        InData    = 8'h01;
        valid_aux = 1'b1;
        @(negedge Clk);
        valid_aux = 1'b0;
        for (int j = 1; j <= 180; j++) begin
            @(negedge Clk);
            e_odd = (j <= 176) ? exp_odd[4'((j - 1) / 16)] : 1'b1;
            e_np  = (j <= 160) ? exp_np[4'((j - 1) / 16)]  : 1'b1;
            chk("odd_tx", 32'(tx_odd), 32'(e_odd));
            chk("np_tx", 32'(tx_np), 32'(e_np));
            chk("odd_done", 32'(done_odd), 32'(j == 177));
            chk("np_done", 32'(done_np), 32'(j == 161));
            chk("odd_busy", 32'(busy_odd), 32'(j <= 176));
            chk("np_busy", 32'(busy_np), 32'(j <= 160));
            chk("odd_ready", 32'(ready_odd), 1);
            chk("np_ready", 32'(ready_np), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
